lcd_char_queue: RTL and testbench
=================================

# lcd_char_queue

Buffers ASCII characters arriving from an upstream producer, such as a UART receiver or a test pattern source, in a small FIFO. It releases them one at a time to the LCD display controller as a one-cycle `write` strobe with `ascii_data`, spaced by a programmable minimum gap so the controller's E-strobe cycle always completes. It sits directly upstream of the display controller, driving its `ascii_data` and `write` inputs.

## Interface
- `DEPTH`, 16: FIFO entries; must be a power of two, 2..256.
- `GAP_CYCLES`, 1000: minimum idle clocks between successive `write` strobes (100 µs at 10 MHz); must be ≥ 1.
- `clk` input 1: system clock, 10 MHz.
- `rst_n` input 1: reset, synchronous, active-low.
- `in_data` input 8: character from producer.
- `in_valid` input 1: `in_data` is valid this cycle.
- `in_ready` output 1: FIFO can accept; a transfer occurs when `in_valid && in_ready` at a rising edge.
- `ctrl_ready` input 1: display controller has finished initialisation and may receive characters.
- `ascii_data` output 8: character presented to the controller; held stable until the next strobe.
- `write` output 1: one-cycle strobe; `ascii_data` is valid when high.
- `level` output $clog2(DEPTH)+1: current FIFO occupancy.
- `overflow` output 1: sticky flag, set when `in_valid` is high while `in_ready` is low; cleared only by reset.

## Operation
- **FIFO**
  - Circular buffer with read and write pointers, each $clog2(DEPTH) bits wide, wrapping naturally.
  - Separate occupancy counter `level`.
  - `in_ready = (level != DEPTH)`.
- **Sanitising:** on push, store bytes outside 0x20..0x7E as 0x3F ('?'). Other bytes are stored unchanged.
- **Pacing FSM** (`pace_state_t`: `IDLE`, `STROBE`, `GAP`):
  - `IDLE`: if `ctrl_ready && level != 0`, then pop the head, register it into `ascii_data`, set `write`=1, and go to `STROBE`. Otherwise remain in `IDLE` with `write`=0.
  - `STROBE`: set `write`=0, load `gap_cnt` = `GAP_CYCLES`-1, and go to `GAP`.
  - `GAP`: decrement `gap_cnt`; when it reaches 0, go to `IDLE`. `ctrl_ready` is ignored in this state.
- **Simultaneous push and pop** in one cycle: `level` is unchanged and both pointers advance.
  - Push into a full FIFO never occurs, because `in_ready` is low.
  - Pop from an empty FIFO never occurs.
- **`ctrl_ready` deasserting mid-sequence:** the current `STROBE`/`GAP` completes, then the FSM holds in `IDLE`. The FIFO keeps accepting input until full.
- **Reset values** (applied at any edge with `rst_n`=0, including mid-operation):
  - `write`=0, `ascii_data`=8'h20, `level`=0, `in_ready`=1, `overflow`=0.
  - Both pointers 0; state `IDLE`; `gap_cnt`=0.
  - FIFO contents are discarded.

## Timing
- **Latency:** a character pushed at edge N into an empty FIFO, with `ctrl_ready`=1 and the FSM in `IDLE`, gives `write` high for exactly the cycle after edge N+1.
- **Strobe spacing:** consecutive `write` pulses are exactly `GAP_CYCLES`+2 clocks apart (rising edge to rising edge) while data is available and `ctrl_ready`=1.
  - Default: 1002 clocks = 100.2 µs.
- **Timing of `in_ready` and `level`:** `in_ready` is combinational from registered `level` and has no dependency on `in_valid`. `level` updates on the edge following the transfer.
- **Output stability:** `ascii_data` changes only on the edge that raises `write`.

## Structure
- **Package `lcd_pkg`** (shared with the display controller):
  - `pace_state_t` enum.
  - `CHAR_SUB` = 8'h3F.
  - `CHAR_MIN` = 8'h20, `CHAR_MAX` = 8'h7E.
  - `CLK_HZ` = 10_000_000.
- **Sub-module `char_fifo`:** a parameterised synchronous FIFO with DEPTH, width 8, and push/pop/level/full/empty. The top level holds the sanitiser, the pacing FSM and the overflow flag.

## Test plan
- **Reset:** hold `rst_n`=0 for 3 cycles mid-stream → `write`=0, `level`=0, `in_ready`=1, `ascii_data`=8'h20; no strobe for at least `GAP_CYCLES` after release with an empty FIFO.
- **Single character:** `ctrl_ready`=1, push 8'h4D at edge N → one `write` pulse in the cycle after edge N+1 with `ascii_data`=8'h4D; `level` returns to 0.
- **Burst pacing:** push "HELLO" back-to-back with `GAP_CYCLES`=1000 → five strobes exactly 1002 cycles apart carrying 48,45,4C,4C,4F in order.
- **Full/overflow:** `ctrl_ready`=0, push 17 bytes with `DEPTH`=16 → `level`=16, `in_ready`=0 after the 16th push, `overflow`=1. Raise `ctrl_ready` → 16 strobes in order with pointer wrap; `overflow` remains 1.
- **Sanitise:** push 8'h0A, 8'h7F, 8'h20, 8'h7E → strobed values 3F, 3F, 20, 7E.
- **Simultaneous push/pop:** with `level`=1, push on the same edge the FSM pops → `level` stays 1; the next strobe carries the new byte.

Source files
------------

// File: rtl/lcd_char_queue_pkg.sv
// Definitions shared by the LCD character queue and the display controller:
// pacing states, printable-character bounds and the sanitiser helper.
package lcd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      STROBE = 2'd1,
      GAP    = 2'd2
   } pace_state_t;

   localparam logic [7:0] CHAR_SUB = 8'h3F;
   localparam logic [7:0] CHAR_MIN = 8'h20;
   localparam logic [7:0] CHAR_MAX = 8'h7E;
   localparam int unsigned CLK_HZ  = 10_000_000;

   // Anything the display cannot render becomes '?'
   function automatic logic [7:0] sanitise_char(input logic [7:0] c);
      logic [7:0] result;
      if ((c >= CHAR_MIN) && (c <= CHAR_MAX)) begin
         result = c;
      end else begin
         result = CHAR_SUB;
      end
      return result;
   endfunction

endpackage

// File: rtl/lcd_char_queue_if.sv
// Producer and display-controller signals of the character queue, bundled
// with the queue as slave and the driving environment as master.
interface lcd_char_queue_if #(
   parameter int DEPTH = 16
);
   localparam int LW = $clog2(DEPTH) + 1;

   logic [7:0]    in_data;
   logic          in_valid;
   logic          in_ready;
   logic          ctrl_ready;
   logic [7:0]    ascii_data;
   logic          write;
   logic [LW-1:0] level;
   logic          overflow;

   modport master (
      output in_data, in_valid, ctrl_ready,
      input  in_ready, ascii_data, write, level, overflow
   );

   modport slave (
      input  in_data, in_valid, ctrl_ready,
      output in_ready, ascii_data, write, level, overflow
   );

endinterface

// File: rtl/lcd_char_queue_char_fifo.sv
// Synchronous circular-buffer FIFO with separate occupancy counter.
// Storage is not reset; only the pointers and count are cleared.
module char_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       push,
   input  logic [WIDTH-1:0]           push_data,
   input  logic                       pop,
   output logic [WIDTH-1:0]           pop_data,
   output logic [$clog2(DEPTH):0]     level,
   output logic                       full,
   output logic                       empty
);
   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;

   logic [WIDTH-1:0] mem_r [DEPTH];
   logic [AW-1:0]    wr_ptr_r;
   logic [AW-1:0]    rd_ptr_r;
   logic [LW-1:0]    level_r;

   assign full     = (level_r == LW'(DEPTH));
   assign empty    = (level_r == LW'(0));
   assign level    = level_r;
   assign pop_data = mem_r[rd_ptr_r];

   // Pointer and occupancy bookkeeping; pointers wrap at the power-of-two depth
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr_r <= '0;
         rd_ptr_r <= '0;
         level_r  <= '0;
      end else begin
         if (push) begin
            wr_ptr_r <= wr_ptr_r + AW'(1);
         end
         if (pop) begin
            rd_ptr_r <= rd_ptr_r + AW'(1);
         end
         case ({push, pop})
            2'b10:   level_r <= level_r + LW'(1);
            2'b01:   level_r <= level_r - LW'(1);
            default: level_r <= level_r;
         endcase
      end
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (push) begin
         mem_r[wr_ptr_r] <= push_data;
      end
   end

endmodule

// File: rtl/lcd_char_queue.sv
// Character queue in front of the LCD controller: sanitises incoming bytes,
// buffers them, and releases one write strobe per GAP_CYCLES+2 clocks.
module lcd_char_queue
   import lcd_pkg::*;
#(
   parameter int DEPTH      = 16,
   parameter int GAP_CYCLES = 1000
) (
   input  logic             clk,
   input  logic             rst_n,
   lcd_char_queue_if.slave  bus
);
   localparam int LW = $clog2(DEPTH) + 1;
   localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

   pace_state_t   state_r;
   pace_state_t   state_nx_s;
   logic [GW-1:0] gap_cnt_r;
   logic [GW-1:0] gap_cnt_nx_s;
   logic          write_r;
   logic [7:0]    ascii_r;
   logic          overflow_r;

   logic          push_s;
   logic          pop_s;
   logic          full_s;
   logic          empty_s;
   logic [7:0]    push_data_s;
   logic [7:0]    head_s;
   logic [LW-1:0] level_s;

   assign push_s      = bus.in_valid && !full_s;
   assign push_data_s = sanitise_char(bus.in_data);
   assign pop_s       = (state_r == IDLE) && bus.ctrl_ready && !empty_s;

   assign bus.in_ready   = !full_s;
   assign bus.level      = level_s;
   assign bus.write      = write_r;
   assign bus.ascii_data = ascii_r;
   assign bus.overflow   = overflow_r;

   char_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push_s),
      .push_data (push_data_s),
      .pop       (pop_s),
      .pop_data  (head_s),
      .level     (level_s),
      .full      (full_s),
      .empty     (empty_s)
   );

   // Pacing FSM next-state; GAP exits on the cycle after gap_cnt reads zero
   always_comb begin
      state_nx_s   = state_r;
      gap_cnt_nx_s = gap_cnt_r;
      case (state_r)
         IDLE: begin
            if (pop_s) begin
               state_nx_s = STROBE;
            end else begin
               state_nx_s = IDLE;
            end
         end
         STROBE: begin
            state_nx_s   = GAP;
            gap_cnt_nx_s = GW'(GAP_CYCLES - 1);
         end
         GAP: begin
            if (gap_cnt_r == GW'(0)) begin
               state_nx_s = IDLE;
            end else begin
               gap_cnt_nx_s = gap_cnt_r - GW'(1);
            end
         end
         default: begin
            state_nx_s   = IDLE;
            gap_cnt_nx_s = GW'(0);
         end
      endcase
   end

   // State, output strobe/data and sticky overflow registers
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r    <= IDLE;
         gap_cnt_r  <= '0;
         write_r    <= 1'b0;
         ascii_r    <= CHAR_MIN;
         overflow_r <= 1'b0;
      end else begin
         state_r   <= state_nx_s;
         gap_cnt_r <= gap_cnt_nx_s;
         write_r   <= pop_s;
         if (pop_s) begin
            ascii_r <= head_s;
         end
         if (bus.in_valid && full_s) begin
            overflow_r <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_lcd_char_queue.sv
// Scoreboard bench for lcd_char_queue: stimulus queues expected strobe bytes,
// a negedge monitor pops and compares them whenever write is high.
module tb_lcd_char_queue;
   import lcd_pkg::*;

   localparam int DEPTH   = 16;
   localparam int GAP     = 1000;
   localparam int SPACING = GAP + 2;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   lcd_char_queue_if #(.DEPTH(DEPTH)) bus();

   lcd_char_queue #(
      .DEPTH      (DEPTH),
      .GAP_CYCLES (GAP)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #50 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int         n_tests = 0;
   int         n_fail  = 0;
   logic [7:0] exp_q[$];
   int         strobe_cyc[$];
   logic [7:0] prev_ascii = 8'h20;
   logic       prev_rst   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // Monitor: compare every strobe against the scoreboard, and watch data stability
   always @(negedge clk) begin
      if (bus.write === 1'b1) begin
         strobe_cyc.push_back(cyc);
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_strobe: got ascii_data %0h, expected no strobe", bus.ascii_data);
         end else begin
            check("strobe_data", {24'd0, bus.ascii_data}, {24'd0, exp_q.pop_front()});
         end
      end else if (rst_n && prev_rst) begin
         check("ascii_stable", {24'd0, bus.ascii_data}, {24'd0, prev_ascii});
      end
      prev_ascii = bus.ascii_data;
      prev_rst   = rst_n;
   end

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [7:0] d, input logic [7:0] e, input logic exp_accept);
      bus.in_data  = d;
      bus.in_valid = 1'b1;
      check("in_ready_before_push", {31'd0, bus.in_ready}, {31'd0, exp_accept});
      if (bus.in_ready === 1'b1) exp_q.push_back(e);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic check_reset_state();
      @(negedge clk);
      check("rst_write",    {31'd0, bus.write},      32'd0);
      check("rst_level",    {27'd0, bus.level},      32'd0);
      check("rst_in_ready", {31'd0, bus.in_ready},   32'd1);
      check("rst_ascii",    {24'd0, bus.ascii_data}, 32'h20);
      check("rst_overflow", {31'd0, bus.overflow},   32'd0);
   endtask

   initial begin
      int base;
      logic [7:0] hello [5];
      hello = '{8'h48, 8'h45, 8'h4C, 8'h4C, 8'h4F};

      bus.in_data    = 8'h00;
      bus.in_valid   = 1'b0;
      bus.ctrl_ready = 1'b0;

      // Power-on reset
      repeat (3) @(posedge clk);
      check_reset_state();
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single character and latency
      bus.ctrl_ready = 1'b1;
      wait_cyc(2);
      push(8'h4D, 8'h4D, 1'b1);
      @(negedge clk);
      check("latency_early_write", {31'd0, bus.write}, 32'd0);
      check("single_level_1",      {27'd0, bus.level}, 32'd1);
      @(posedge clk);
      @(negedge clk);
      check("latency_strobe_write", {31'd0, bus.write}, 32'd1);
      check("single_level_0",       {27'd0, bus.level}, 32'd0);
      wait_cyc(SPACING + 5);

      // Burst pacing "HELLO"
      base = strobe_cyc.size();
      for (int i = 0; i < 5; i++) push(hello[i], hello[i], 1'b1);
      wait_cyc(5 * SPACING + 10);
      check("burst_count", strobe_cyc.size(), base + 5);
      if (strobe_cyc.size() == base + 5) begin
         for (int i = 1; i < 5; i++)
            check("burst_spacing", strobe_cyc[base + i] - strobe_cyc[base + i - 1], SPACING);
      end

      // Fill to full, then overflow
      bus.ctrl_ready = 1'b0;
      for (int i = 0; i < 16; i++) push(8'h61 + 8'(i), 8'h61 + 8'(i), 1'b1);
      check("full_level",    {27'd0, bus.level},    32'd16);
      check("full_in_ready", {31'd0, bus.in_ready}, 32'd0);
      push(8'h71, 8'h71, 1'b0);
      check("overflow_set", {31'd0, bus.overflow}, 32'd1);
      base = strobe_cyc.size();
      wait_cyc(5);
      check("full_hold_level", {27'd0, bus.level}, 32'd16);
      check("full_no_strobe",  strobe_cyc.size(), base);
      bus.ctrl_ready = 1'b1;
      wait_cyc(16 * SPACING + 10);
      check("drain_count",     strobe_cyc.size(), base + 16);
      check("drain_level",     {27'd0, bus.level},    32'd0);
      check("overflow_sticky", {31'd0, bus.overflow}, 32'd1);

      // Sanitiser
      push(8'h0A, 8'h3F, 1'b1);
      push(8'h7F, 8'h3F, 1'b1);
      push(8'h20, 8'h20, 1'b1);
      push(8'h7E, 8'h7E, 1'b1);
      wait_cyc(4 * SPACING + 10);

      // Simultaneous push and pop at level 1
      bus.ctrl_ready = 1'b0;
      push(8'h41, 8'h41, 1'b1);
      wait_cyc(2);
      check("simul_pre_level", {27'd0, bus.level}, 32'd1);
      bus.ctrl_ready = 1'b1;
      bus.in_data    = 8'h42;
      bus.in_valid   = 1'b1;
      check("simul_in_ready", {31'd0, bus.in_ready}, 32'd1);
      exp_q.push_back(8'h42);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      check("simul_level", {27'd0, bus.level}, 32'd1);
      check("simul_write", {31'd0, bus.write}, 32'd1);
      wait_cyc(2 * SPACING + 10);
      check("simul_drained", {27'd0, bus.level}, 32'd0);

      // Reset mid-stream, then silence with an empty FIFO
      push(8'h58, 8'h58, 1'b1);
      push(8'h59, 8'h59, 1'b1);
      push(8'h5A, 8'h5A, 1'b1);
      wait_cyc(10);
      rst_n = 1'b0;
      exp_q.delete();
      repeat (3) @(posedge clk);
      check_reset_state();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      base = strobe_cyc.size();
      wait_cyc(GAP + 10);
      check("post_reset_no_strobe", strobe_cyc.size(), base);
      check("post_reset_level",     {27'd0, bus.level}, 32'd0);

      check("scoreboard_drained", exp_q.size(), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
